// File: rtl/game_pkg.sv
// Shared types for the game session controller: control modes, session states
// and the schedule entry format.
package game_pkg;

  typedef enum logic [1:0] {
    CTRL_UP1 = 2'b00,
    CTRL_UP2 = 2'b01,
    CTRL_DN1 = 2'b10,
    CTRL_DN2 = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } sess_state_e;

  localparam int unsigned SCHED_DEPTH = 4;
  // Widest dwell field supported; narrower DWELL_W values are zero-extended into it.
  localparam int unsigned DWELL_W_MAX = 16;

  typedef struct packed {
    ctrl_e                  ctrl;
    logic [DWELL_W_MAX-1:0] dwell;
  } sched_entry_t;

  localparam sched_entry_t SCHED_RESET = '{ctrl: CTRL_UP1, dwell: DWELL_W_MAX'(1)};

  // A dwell of zero still holds its mode for one cycle.
  function automatic logic [DWELL_W_MAX-1:0] eff_dwell(input sched_entry_t e);
    return (e.dwell == '0) ? DWELL_W_MAX'(1) : e.dwell;
  endfunction

endpackage

// File: rtl/game_session_ctrl_if.sv
// Host/core-facing signal bundle of game_session_ctrl. The master side is the
// host registers plus the full_game core; the slave side is the controller.
interface game_session_ctrl_if #(
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned SCORE_W = 8
);
  logic               start;
  logic [3:0]         seed;
  logic               prog_wr;
  logic [1:0]         prog_addr;
  logic [DWELL_W+1:0] prog_data;
  logic               gameover;
  logic               who;
  logic               init;
  logic [3:0]         initial_val;
  logic [1:0]         control;
  logic               busy;
  logic               done;
  logic               winner;
  logic               timeout;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;

  modport master (
    output start, seed, prog_wr, prog_addr, prog_data, gameover, who,
    input  init, initial_val, control, busy, done, winner, timeout, score_a, score_b
  );

  modport slave (
    input  start, seed, prog_wr, prog_addr, prog_data, gameover, who,
    output init, initial_val, control, busy, done, winner, timeout, score_a, score_b
  );
endinterface

// File: rtl/game_step_timer.sv
// Mode schedule for game_session_ctrl: four programmable {ctrl, dwell} entries,
// the current entry index and the dwell down-counter that advances it.
module game_step_timer
  import game_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [DWELL_W+1:0] wr_data,
  input  logic               restart,
  input  logic               run_start,
  input  logic               step,
  output ctrl_e              ctrl
);

  sched_entry_t           sched [SCHED_DEPTH];
  logic [1:0]             idx;
  logic [1:0]             idx_next;
  logic [DWELL_W_MAX-1:0] remain;
  logic                   last_cycle;

  assign idx_next   = idx + 2'd1;
  assign last_cycle = (remain <= DWELL_W_MAX'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the schedule is a few flops rather than a RAM, so it takes the async reset like any other state.
      for (int i = 0; i < SCHED_DEPTH; i++) sched[i] <= SCHED_RESET;
      idx    <= '0;
      remain <= DWELL_W_MAX'(1);
    end else begin
      if (wr_en)
        sched[wr_addr] <= '{ctrl:  ctrl_e'(wr_data[DWELL_W +: 2]),
                            dwell: DWELL_W_MAX'(wr_data[DWELL_W-1:0])};

      if (restart)
        idx <= '0;
      else if (step && last_cycle)
        idx <= idx_next;

      // remain counts the cycles left in the current entry, including this one.
      if (run_start)
        remain <= eff_dwell(sched[0]);
      else if (step)
        remain <= last_cycle ? eff_dwell(sched[idx_next]) : remain - DWELL_W_MAX'(1);
    end
  end

  assign ctrl = sched[idx].ctrl;

endmodule

// File: rtl/game_session_ctrl.sv
// Session controller for the full_game core: seed load, scheduled mode stepping,
// winner/score keeping. Define GAME_TIMEOUT_EN to add the RUN-state watchdog.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DWELL_W     = 4,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned TIMEOUT_CYC = 512
) (
  input logic clk,
  input logic rst_n,
  game_session_ctrl_if.slave bus
);

  localparam int unsigned LOAD_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  sess_state_e        state;
  logic [LOAD_W-1:0]  load_cnt;
  logic               init_q;
  logic [3:0]         initial_val_q;
  logic               busy_q;
  logic               done_q;
  logic               winner_q;
  logic               timeout_q;
  logic [SCORE_W-1:0] score_a_q;
  logic [SCORE_W-1:0] score_b_q;

  logic  restart;
  logic  run_start;
  logic  wr_en;
  logic  step;
  logic  wd_hit;
  ctrl_e cur_ctrl;

  assign restart   = (state == IDLE) && bus.start;
  assign run_start = (state == LOAD) && (load_cnt == '0);
  assign wr_en     = (state == IDLE) && bus.prog_wr;
  // The schedule freezes on the game-ending edge so DONE shows the final mode.
  assign step      = (state == RUN) && !bus.gameover && !wd_hit;

  game_step_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (bus.prog_addr),
    .wr_data   (bus.prog_data),
    .restart   (restart),
    .run_start (run_start),
    .step      (step),
    .ctrl      (cur_ctrl)
  );

`ifdef GAME_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_cnt <= '0;
    else if (state != RUN)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WD_W'(1);
  end

  // wd_cnt is 0 in the first RUN cycle, so this fires in RUN cycle TIMEOUT_CYC.
  assign wd_hit = (state == RUN) && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign wd_hit             = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      load_cnt      <= '0;
      init_q        <= 1'b0;
      initial_val_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      winner_q      <= 1'b0;
      timeout_q     <= 1'b0;
      score_a_q     <= '0;
      score_b_q     <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge values; the pulse defaults are overridden below.
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= LOAD;
            init_q        <= 1'b1;
            initial_val_q <= bus.seed;
            busy_q        <= 1'b1;
            load_cnt      <= LOAD_W'(INIT_CYCLES - 1);
          end
        end
        LOAD: begin
          if (load_cnt == '0) begin
            state  <= RUN;
            init_q <= 1'b0;
          end else begin
            load_cnt <= load_cnt - LOAD_W'(1);
          end
        end
        RUN: begin
          if (bus.gameover) begin
            state    <= DONE;
            done_q   <= 1'b1;
            winner_q <= bus.who;
            if (bus.who) begin
              if (score_a_q != '1) score_a_q <= score_a_q + SCORE_W'(1);
            end else begin
              if (score_b_q != '1) score_b_q <= score_b_q + SCORE_W'(1);
            end
          end else if (wd_hit) begin
            state     <= DONE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.init        = init_q;
  assign bus.initial_val = initial_val_q;
  assign bus.control     = busy_q ? cur_ctrl : CTRL_UP1;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.winner      = winner_q;
  assign bus.timeout     = timeout_q;
  assign bus.score_a     = score_a_q;
  assign bus.score_b     = score_b_q;

endmodule

// File: tb/tb_game_session_ctrl.sv
// Self-checking bench for game_session_ctrl: a session-level reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_game_session_ctrl;

  localparam int DWELL_W     = 4;
  localparam int SCORE_W     = 8;
  localparam int INIT_CYCLES = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int SCORE_MAX   = (1 << SCORE_W) - 1;
`ifdef GAME_TIMEOUT_EN
  localparam bit M_WD   = 1'b1;
  localparam int GO_CYC = 12;
`else
  localparam bit M_WD   = 1'b0;
  localparam int GO_CYC = 40;
`endif

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DONE = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  game_session_ctrl_if #(.DWELL_W(DWELL_W), .SCORE_W(SCORE_W)) bus ();

  game_session_ctrl #(
    .DWELL_W     (DWELL_W),
    .INIT_CYCLES (INIT_CYCLES),
    .SCORE_W     (SCORE_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int       m_phase = P_IDLE;
  int       m_load_left = 0;
  int       m_run_t = 0;
  int       m_ival = 0;
  int       m_winner = 0;
  int       m_timeout = 0;
  int       m_score_a = 0;
  int       m_score_b = 0;
  int       m_frozen = 0;
  int       m_ctrl  [4] = '{0, 0, 0, 0};
  int       m_dwell [4] = '{1, 1, 1, 1};

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  // Mode in RUN cycle t (1-based): position within one full pass of the schedule.
  function automatic int ctrl_at(input int t);
    int total = 0;
    int r;
    for (int i = 0; i < 4; i++) total += eff(m_dwell[i]);
    r = (t - 1) % total;
    for (int i = 0; i < 4; i++) begin
      if (r < eff(m_dwell[i])) return m_ctrl[i];
      r -= eff(m_dwell[i]);
    end
    return 0;
  endfunction

  function automatic int exp_ctrl();
    case (m_phase)
      P_LOAD:  return m_ctrl[0];
      P_RUN:   return ctrl_at(m_run_t);
      P_DONE:  return m_frozen;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_ival = 0; m_winner = 0; m_timeout = 0;
      m_score_a = 0; m_score_b = 0; m_frozen = 0; m_run_t = 0; m_load_left = 0;
      for (int i = 0; i < 4; i++) begin m_ctrl[i] = 0; m_dwell[i] = 1; end
    end else begin
      case (m_phase)
        P_IDLE: begin
          if (bus.prog_wr) begin
            m_ctrl[bus.prog_addr]  = int'(bus.prog_data[DWELL_W +: 2]);
            m_dwell[bus.prog_addr] = int'(bus.prog_data[DWELL_W-1:0]);
          end
          if (bus.start) begin
            m_phase = P_LOAD; m_ival = int'(bus.seed); m_load_left = INIT_CYCLES;
          end
        end
        P_LOAD: begin
          m_load_left--;
          if (m_load_left == 0) begin m_phase = P_RUN; m_run_t = 1; end
        end
        P_RUN: begin
          if (bus.gameover) begin
            m_frozen = ctrl_at(m_run_t); m_phase = P_DONE; m_timeout = 0;
            m_winner = int'(bus.who);
            if (bus.who) begin if (m_score_a < SCORE_MAX) m_score_a++; end
            else begin if (m_score_b < SCORE_MAX) m_score_b++; end
          end else if (M_WD && m_run_t == TIMEOUT_CYC) begin
            m_frozen = ctrl_at(m_run_t); m_phase = P_DONE; m_timeout = 1;
          end else begin
            m_run_t++;
          end
        end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("init",        bus.init,        32'(m_phase == P_LOAD));
      check("initial_val", bus.initial_val, m_ival);
      check("control",     bus.control,     exp_ctrl());
      check("busy",        bus.busy,        32'(m_phase != P_IDLE));
      check("done",        bus.done,        32'(m_phase == P_DONE));
      check("timeout",     bus.timeout,     32'(m_phase == P_DONE && m_timeout != 0));
      check("winner",      bus.winner,      m_winner);
      check("score_a",     bus.score_a,     m_score_a);
      check("score_b",     bus.score_b,     m_score_b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_prog(input logic [1:0] a, input logic [1:0] c, input logic [3:0] d);
    bus.prog_wr = 1'b1; bus.prog_addr = a; bus.prog_data = {c, d};
  endtask

  // Returns in LOAD cycle 1.
  task automatic start_game(input logic [3:0] s);
    bus.start = 1'b1; bus.seed = s;
    tick();
    bus.start = 1'b0; bus.prog_wr = 1'b0;
  endtask

  // Called in the RUN cycle that sees gameover; returns in the DONE cycle.
  task automatic end_game(input logic w);
    bus.gameover = 1'b1; bus.who = w;
    tick();
    bus.gameover = 1'b0; bus.who = 1'b0;
  endtask

  logic [1:0] exp_seq  [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
  logic [1:0] exp_seq2 [8]  = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};

  initial begin
    bus.start = 1'b0; bus.seed = '0; bus.prog_wr = 1'b0; bus.prog_addr = '0;
    bus.prog_data = '0; bus.gameover = 1'b0; bus.who = 1'b0;
    rst_n = 1'b0;
    ticks(3);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("rst_busy", bus.busy, 0);
    check("rst_control", bus.control, 0);
    check("rst_scores", {bus.score_a, bus.score_b}, 0);

    // Game 1: programmed schedule, seed 5, player A wins.
    set_prog(2'd0, 2'b00, 4'd3); tick();
    set_prog(2'd1, 2'b01, 4'd2); tick();
    set_prog(2'd2, 2'b10, 4'd1); tick();
    set_prog(2'd3, 2'b11, 4'd4); tick();
    bus.prog_wr = 1'b0;
    start_game(4'd5);
    check("g1_load1_init", bus.init, 1);
    check("g1_load1_ival", bus.initial_val, 5);
    tick();
    check("g1_load2_init", bus.init, 1);
    tick();
    check("g1_run1_init", bus.init, 0);
    for (int i = 1; i < GO_CYC; i++) begin
      check("g1_seq", bus.control, exp_seq[(i - 1) % 10]);
      tick();
    end
    end_game(1'b1);
    check("g1_done", bus.done, 1);
    check("g1_winner", bus.winner, 1);
    check("g1_score_a", bus.score_a, 1);
    check("g1_score_b", bus.score_b, 0);
    check("g1_frozen", bus.control, exp_seq[(GO_CYC - 1) % 10]);
    tick();
    check("g1_idle_busy", bus.busy, 0);
    check("g1_idle_done", bus.done, 0);

    // Game 2: start and prog_wr during RUN are ignored; player B wins.
    start_game(4'd9);
    ticks(2);
    ticks(2);
    bus.start = 1'b1; bus.seed = 4'd2; set_prog(2'd0, 2'b11, 4'd5);
    tick();
    bus.start = 1'b0; bus.prog_wr = 1'b0;
    check("g2_no_restart", bus.init, 0);
    check("g2_run4_ctrl", bus.control, 1);
    ticks(8);
    end_game(1'b0);
    check("g2_winner", bus.winner, 0);
    check("g2_score_b", bus.score_b, 1);
    tick();

    // Game 3: schedule must be unchanged by the dropped write.
    start_game(4'd3);
    check("g3_load_ctrl", bus.control, 0);
    ticks(2);
    check("g3_run1_ctrl", bus.control, 0);
    ticks(3);
    check("g3_run4_ctrl", bus.control, 1);
    end_game(1'b1);
    check("g3_score_a", bus.score_a, 2);
    tick();

    // Game 4: dwell=0 entry and a write issued together with start.
    set_prog(2'd3, 2'b11, 4'd0); tick();
    set_prog(2'd0, 2'b10, 4'd2);
    start_game(4'd12);
    check("g4_load_ctrl", bus.control, 2);
    ticks(2);
    for (int i = 0; i < 8; i++) begin
      check("g4_seq", bus.control, exp_seq2[i]);
      if (i < 7) tick();
    end
    end_game(1'b0);
    check("g4_score_b", bus.score_b, 2);
    tick();

    // Async reset in the middle of RUN.
    start_game(4'd7);
    ticks(2 + 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_control", bus.control, 0);
    check("mid_rst_ival", bus.initial_val, 0);
    check("mid_rst_scores", {bus.score_a, bus.score_b}, 0);
    check("mid_rst_init_done", {bus.init, bus.done, bus.winner, bus.timeout}, 0);
    ticks(2);
    rst_n = 1'b1;
    tick();

    // 256 games won by player B: score_b saturates.
    for (int g = 0; g < 256; g++) begin
      start_game(4'(g));
      ticks(2);
      end_game(1'b0);
      tick();
    end
    check("sat_score_b", bus.score_b, 255);
    check("sat_score_a", bus.score_a, 0);

    // Watchdog (or its absence).
    start_game(4'd1);
    ticks(2);
`ifdef GAME_TIMEOUT_EN
    ticks(TIMEOUT_CYC - 1);
    check("wd_run16_done", bus.done, 0);
    tick();
    check("wd_done", bus.done, 1);
    check("wd_timeout", bus.timeout, 1);
    check("wd_score_b", bus.score_b, 255);
    check("wd_score_a", bus.score_a, 0);
    tick();
    check("wd_idle_busy", bus.busy, 0);
`else
    ticks(1000);
    check("nowd_busy", bus.busy, 1);
    check("nowd_done", bus.done, 0);
    check("nowd_timeout", bus.timeout, 0);
    end_game(1'b1);
    check("nowd_end_score_a", bus.score_a, 1);
    tick();
`endif

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
